// File: rtl/button_event_decoder.sv
// Button conditioner: 2-flop synchronizer, debouncer and gesture FSM that
// turns the raw active-low pin into single-cycle press/release/short/long/double events.
module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_CYCLES       = 12000000,
    parameter int DOUBLE_GAP_CYCLES = 3600000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic USER_BTN,
    output logic BTN_LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic SHORT_PRESS,
    output logic LONG_PRESS,
    output logic DOUBLE_PRESS
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int GW = $clog2(DOUBLE_GAP_CYCLES + 1);

    localparam logic [DW-1:0] DC_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HC_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HC_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [GW-1:0] GC_LAST = GW'(DOUBLE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_HELD
    } state_t;

    logic [1:0]    sync_q;
    logic          s;
    logic          db;
    logic [DW-1:0] dc;
    logic          toggle;
    logic          press_evt;
    logic          release_evt;
    state_t        state;
    logic [HW-1:0] hc;
    logic [GW-1:0] gc;

    // Both stages reset to the released level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], USER_BTN};
        end
    end

    assign s = ~sync_q[1];

    // Level flips only once the disagreement has persisted for the full window.
    assign toggle      = (s != db) && (dc == DC_MAX);
    assign press_evt   = toggle && !db;
    assign release_evt = toggle && db;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db      <= 1'b0;
            dc      <= '0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
        end else begin
            PRESS   <= press_evt;
            RELEASE <= release_evt;
            if (s == db) begin
                dc <= '0;
            end else if (toggle) begin
                db <= ~db;
                dc <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end

    assign BTN_LEVEL = db;

    // Gesture FSM reacts to the same-edge debounce events so its pulses align with PRESS/RELEASE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            hc           <= '0;
            gc           <= '0;
            SHORT_PRESS  <= 1'b0;
            LONG_PRESS   <= 1'b0;
            DOUBLE_PRESS <= 1'b0;
        end else begin
            SHORT_PRESS  <= 1'b0;
            LONG_PRESS   <= 1'b0;
            DOUBLE_PRESS <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_evt) begin
                        state <= HELD;
                        hc    <= '0;
                    end
                end
                HELD: begin
                    if (release_evt) begin
                        state <= WAIT_SECOND;
                        gc    <= '0;
                    end else begin
                        if (hc != HC_MAX) hc <= hc + 1'b1;
                        if (hc == HC_LAST) begin
                            LONG_PRESS <= 1'b1;
                            state      <= LONG_HELD;
                        end
                    end
                end
                LONG_HELD: begin
                    if (release_evt) state <= IDLE;
                end
                WAIT_SECOND: begin
                    // A press on the expiry cycle still counts as a double.
                    if (press_evt) begin
                        DOUBLE_PRESS <= 1'b1;
                        state        <= SECOND_HELD;
                    end else if (gc == GC_LAST) begin
                        SHORT_PRESS <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gc <= gc + 1'b1;
                    end
                end
                SECOND_HELD: begin
                    if (release_evt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: table of pin segments with hand-computed event
// cycles; a scoreboard matches every output pulse against the expected cycle.
module tb_button_event_decoder;

    localparam int D = 4;
    localparam int L = 20;
    localparam int G = 10;

    localparam int EP = 0;
    localparam int ER = 1;
    localparam int ES = 2;
    localparam int EL = 3;
    localparam int ED = 4;
    localparam int NO = -1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic user_btn = 1'b1;
    logic btn_level, press, release_o, short_press, long_press, double_press;

    button_event_decoder #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .DOUBLE_GAP_CYCLES(G)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .USER_BTN(user_btn),
        .BTN_LEVEL(btn_level),
        .PRESS(press),
        .RELEASE(release_o),
        .SHORT_PRESS(short_press),
        .LONG_PRESS(long_press),
        .DOUBLE_PRESS(double_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    typedef struct {
        logic btn;
        int   len;
        logic lvl;
        int   ev0;
        int   off0;
        int   ev1;
        int   off1;
    } seg_t;

    exp_t  sb[$];
    seg_t  tbl[$];
    int    checks = 0;
    int    errors = 0;
    int    midx;
    logic [4:0] pulses;
    string kname[5] = '{"PRESS", "RELEASE", "SHORT_PRESS", "LONG_PRESS", "DOUBLE_PRESS"};

    // Every pulse must match a queued expectation at this cycle; anything left overdue was missed.
    always @(negedge clk) begin
        pulses = {double_press, long_press, short_press, release_o, press};
        for (int k = 0; k < 5; k++) begin
            if (pulses[k]) begin
                midx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (sb[i].kind == k && sb[i].at == cyc) midx = i;
                checks++;
                if (midx < 0) begin
                    errors++;
                    $display("FAIL %s: pulse seen at cycle %0d, none expected", kname[k], cyc);
                end else begin
                    sb.delete(midx);
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: no pulse seen, expected at cycle %0d", kname[sb[i].kind], sb[i].at);
                sb.delete(i);
            end
        end
    end

    function automatic seg_t mk(logic b, int len, logic lvl, int e0, int o0, int e1, int o1);
        seg_t r;
        r.btn = b; r.len = len; r.lvl = lvl;
        r.ev0 = e0; r.off0 = o0; r.ev1 = e1; r.off1 = o1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, want);
        end
    endtask

    // Entered #1 after an edge; the pin value is first sampled at the next edge (t).
    task automatic apply(input seg_t sg);
        int t;
        user_btn = sg.btn;
        t = cyc + 1;
        if (sg.ev0 >= 0) sb.push_back('{sg.ev0, t + sg.off0});
        if (sg.ev1 >= 0) sb.push_back('{sg.ev1, t + sg.off1});
        repeat (sg.len) @(posedge clk);
        #1;
        chk("btn_level", {5'b0, btn_level}, {5'b0, sg.lvl});
    endtask

    function automatic logic [5:0] outs();
        return {btn_level, press, release_o, short_press, long_press, double_press};
    endfunction

    initial begin
        // bounce rejection, then a clean short press
        tbl.push_back(mk(1'b0, 3, 1'b0, NO, 0, NO, 0));
        tbl.push_back(mk(1'b1, 1, 1'b0, NO, 0, NO, 0));
        tbl.push_back(mk(1'b0, 3, 1'b0, NO, 0, NO, 0));
        tbl.push_back(mk(1'b1, 10, 1'b0, NO, 0, NO, 0));
        tbl.push_back(mk(1'b0, 14, 1'b1, EP, 6, NO, 0));
        tbl.push_back(mk(1'b1, 30, 1'b0, ER, 6, ES, 6 + G));
        // long press
        tbl.push_back(mk(1'b0, 40, 1'b1, EP, 6, EL, 6 + L));
        tbl.push_back(mk(1'b1, 30, 1'b0, ER, 6, NO, 0));
        // double press, second PRESS 5 cycles after RELEASE, second hold long
        tbl.push_back(mk(1'b0, 14, 1'b1, EP, 6, NO, 0));
        tbl.push_back(mk(1'b1, 5, 1'b1, ER, 6, NO, 0));
        tbl.push_back(mk(1'b0, 45, 1'b1, EP, 6, ED, 6));
        tbl.push_back(mk(1'b1, 30, 1'b0, ER, 6, NO, 0));
        // second PRESS exactly on the gap expiry cycle
        tbl.push_back(mk(1'b0, 14, 1'b1, EP, 6, NO, 0));
        tbl.push_back(mk(1'b1, G, 1'b0, ER, 6, NO, 0));
        tbl.push_back(mk(1'b0, 14, 1'b1, EP, 6, ED, 6));
        tbl.push_back(mk(1'b1, 30, 1'b0, ER, 6, NO, 0));

        // reset with the pin toggling
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            user_btn = ~user_btn;
            chk("outputs_in_reset", outs(), 6'b0);
        end
        user_btn = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("outputs_after_reset", outs(), 6'b0);

        foreach (tbl[i]) apply(tbl[i]);

        // reset 3 cycles after RELEASE must drop the pending SHORT_PRESS
        apply(mk(1'b1, 5, 1'b0, NO, 0, NO, 0));
        apply(mk(1'b0, 14, 1'b1, EP, 6, NO, 0));
        apply(mk(1'b1, 9, 1'b0, ER, 6, NO, 0));
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("outputs_mid_reset", outs(), 6'b0);
        end
        rst_n = 1'b1;
        apply(mk(1'b1, 30, 1'b0, NO, 0, NO, 0));
        // FSM must be back in IDLE: a fresh gesture yields SHORT_PRESS, not DOUBLE_PRESS
        apply(mk(1'b0, 14, 1'b1, EP, 6, NO, 0));
        apply(mk(1'b1, 30, 1'b0, ER, 6, ES, 6 + G));

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
